// File: rtl/winograd_pkg.sv
// winograd_pkg: shared definitions for the Winograd F(4x4,3x3) tile engine.
// Holds the data widths, tile sizes, the scaled transform coefficient sets
// (G' = 24*G, B^T, A^T), the controller state enum, the packed word-array
// types used on the tile_controller ports, and two helper functions:
//   coef - look up one coefficient of a selected transform matrix
//   cmul - multiply a 64-bit value by a small constant using shifts and adds
package winograd_pkg;

  localparam int DW     = 32;  // external word width
  localparam int DW_INT = 64;  // internal arithmetic width
  localparam int KN     = 3;   // kernel side
  localparam int TN     = 6;   // input tile side
  localparam int YN     = 4;   // output tile side

  // Multiplicative inverse of 9 modulo 2^64. Dividing an exact multiple of
  // 576 = 64*9 is done by dropping six zero bits and multiplying by this.
  localparam logic [DW_INT-1:0] INV9 = 64'h8E38E38E38E38E39;

  localparam int G_COEF [TN][KN] = '{
    '{ 6,  0,  0},
    '{-4, -4, -4},
    '{-4,  4, -4},
    '{ 1,  2,  4},
    '{ 1, -2,  4},
    '{ 0,  0, 24}
  };

  localparam int BT_COEF [TN][TN] = '{
    '{4,  0, -5,  0, 1, 0},
    '{0, -4, -4,  1, 1, 0},
    '{0,  4, -4, -1, 1, 0},
    '{0, -2, -1,  2, 1, 0},
    '{0,  2, -1, -2, 1, 0},
    '{0,  4,  0, -5, 0, 1}
  };

  localparam int AT_COEF [YN][TN] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  typedef enum logic [1:0] {COEF_G, COEF_B, COEF_A} coef_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_XF1, ST_XF2, ST_MUL, ST_OUT1, ST_OUT2, ST_DONE
  } state_e;

  typedef logic [0:KN-1][0:KN-1][DW-1:0] word3x3_t;
  typedef logic [0:TN-1][0:TN-1][DW-1:0] word6x6_t;
  typedef logic [0:YN-1][0:YN-1][DW-1:0] word4x4_t;

  typedef logic signed [DW_INT-1:0] wide_t;

  function automatic int coef(input coef_sel_e sel, input int r, input int k);
    case (sel)
      COEF_G:  return G_COEF[r][k];
      COEF_B:  return BT_COEF[r][k];
      default: return AT_COEF[r][k];
    endcase
  endfunction

  // All coefficients have magnitude below 32, so five shifted partial
  // terms cover every case; with a constant c this folds to a few adders.
  function automatic wide_t cmul(input wide_t x, input int c);
    wide_t acc;
    int    mag;
    acc = '0;
    mag = (c < 0) ? -c : c;
    for (int k = 0; k < 5; k++) begin
      if (mag[k]) acc = acc + (x <<< k);
    end
    return (c < 0) ? -acc : acc;
  endfunction

endpackage

// File: rtl/winograd_transform.sv
// winograd_transform: combinational constant-matrix x matrix unit.
// Computes y = C * x where C is the R x K coefficient matrix picked by SEL
// (G', B^T or A^T) and x is a K x N matrix of 64-bit signed words.
// Right-multiplication by C^T is obtained by the caller feeding a transposed
// operand and transposing the result.
// Ports:
//   x  input  [K][N] x 64  signed operand matrix
//   y  output [R][N] x 64  signed product matrix (wraps modulo 2^64)
module winograd_transform
  import winograd_pkg::*;
#(
  parameter coef_sel_e SEL = COEF_G,
  parameter int        R   = 6,
  parameter int        K   = 3,
  parameter int        N   = 3
) (
  input  wide_t x [K][N],
  output wide_t y [R][N]
);

  always_comb begin
    for (int r = 0; r < R; r++) begin
      for (int n = 0; n < N; n++) begin
        wide_t acc;
        acc = '0;
        for (int k = 0; k < K; k++) begin
          acc = acc + cmul(x[k][n], coef(SEL, r, k));
        end
        y[r][n] = acc;
      end
    end
  end

endmodule

// File: rtl/tile_controller.sv
// tile_controller: per-tile Winograd F(4x4,3x3) compute engine.
// On start (in IDLE) the kernel g and tile d are captured, then the block
// walks XF1 (G'g, B^T d), XF2 (U', V), MUL (M = U' .* V), OUT1 (A^T M),
// OUT2 (.A, /576, register result) and DONE (one-cycle done pulse).
// All arithmetic is modulo 2^64, which keeps the low 32 result bits exact.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH despite the name
//   start      one-cycle request, honoured only in IDLE
//   kernel_in  3x3 signed 32-bit kernel
//   tile_in    6x6 signed 32-bit input tile
//   result_out 4x4 signed 32-bit result, held until the next OUT2
//   done       one-cycle completion pulse
module tile_controller
  import winograd_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  input  word3x3_t kernel_in,
  input  word6x6_t tile_in,
  output word4x4_t result_out,
  output logic     done
);

  state_e   state_reg, state_next;

  wide_t    g_reg  [KN][KN];
  wide_t    d_reg  [TN][TN];
  wide_t    gt_reg [TN][KN];   // G' * g
  wide_t    bd_reg [TN][TN];   // B^T * d
  wide_t    u_reg  [TN][TN];
  wide_t    v_reg  [TN][TN];
  wide_t    m_reg  [TN][TN];
  wide_t    am_reg [YN][TN];   // A^T * M
  word4x4_t result_reg, result_next;

  wide_t    gt_w  [TN][KN];
  wide_t    gt_tr [KN][TN];
  wide_t    gu_w  [TN][TN];    // U'^T
  wide_t    bd_w  [TN][TN];
  wide_t    bd_tr [TN][TN];
  wide_t    bv_w  [TN][TN];    // V^T
  wide_t    m_next [TN][TN];
  wide_t    am_w  [YN][TN];
  wide_t    am_tr [TN][YN];
  wide_t    ya_w  [YN][YN];    // (576*Y)^T

  winograd_transform #(.SEL(COEF_G), .R(TN), .K(KN), .N(KN)) u_xg1 (.x(g_reg),  .y(gt_w));
  winograd_transform #(.SEL(COEF_G), .R(TN), .K(KN), .N(TN)) u_xg2 (.x(gt_tr),  .y(gu_w));
  winograd_transform #(.SEL(COEF_B), .R(TN), .K(TN), .N(TN)) u_xb1 (.x(d_reg),  .y(bd_w));
  winograd_transform #(.SEL(COEF_B), .R(TN), .K(TN), .N(TN)) u_xb2 (.x(bd_tr),  .y(bv_w));
  winograd_transform #(.SEL(COEF_A), .R(YN), .K(TN), .N(TN)) u_xa1 (.x(m_reg),  .y(am_w));
  winograd_transform #(.SEL(COEF_A), .R(YN), .K(TN), .N(YN)) u_xa2 (.x(am_tr),  .y(ya_w));

  // X * C^T == (C * X^T)^T: feed transposed operands to the second passes.
  always_comb begin
    for (int i = 0; i < TN; i++) begin
      for (int j = 0; j < KN; j++) gt_tr[j][i] = gt_reg[i][j];
      for (int j = 0; j < TN; j++) bd_tr[j][i] = bd_reg[i][j];
      for (int j = 0; j < YN; j++) am_tr[i][j] = am_reg[j][i];
    end
  end

  // Element-wise product: the only true multipliers in the datapath.
  always_comb begin
    for (int i = 0; i < TN; i++) begin
      for (int j = 0; j < TN; j++) begin
        m_next[i][j] = u_reg[i][j] * v_reg[i][j];
      end
    end
  end

  // Exact division by 576: the low six bits are zero, so take bits [63:6]
  // (9*Y mod 2^58) and multiply by 9^-1 mod 2^64 to recover Y mod 2^58.
  for (genvar gi = 0; gi < YN; gi++) begin : g_div_row
    for (genvar gj = 0; gj < YN; gj++) begin : g_div_col
      wide_t              y576;
      logic [DW_INT-1:0]  quot;
      logic               unused_bits;
      assign y576 = ya_w[gj][gi];
      assign quot = {6'b0, y576[DW_INT-1:6]} * INV9;
      assign result_next[gi][gj] = quot[DW-1:0];
      assign unused_bits = ^{quot[DW_INT-1:DW], y576[5:0]};
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_XF1;
      ST_XF1:  state_next = ST_XF2;
      ST_XF2:  state_next = ST_MUL;
      ST_MUL:  state_next = ST_OUT1;
      ST_OUT1: state_next = ST_OUT2;
      ST_OUT2: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg  <= ST_IDLE;
      g_reg      <= '{default: '0};
      d_reg      <= '{default: '0};
      gt_reg     <= '{default: '0};
      bd_reg     <= '{default: '0};
      u_reg      <= '{default: '0};
      v_reg      <= '{default: '0};
      m_reg      <= '{default: '0};
      am_reg     <= '{default: '0};
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < KN; i++)
              for (int j = 0; j < KN; j++)
                g_reg[i][j] <= DW_INT'($signed(kernel_in[i][j]));
            for (int i = 0; i < TN; i++)
              for (int j = 0; j < TN; j++)
                d_reg[i][j] <= DW_INT'($signed(tile_in[i][j]));
          end
        end
        ST_XF1: begin
          gt_reg <= gt_w;
          bd_reg <= bd_w;
        end
        ST_XF2: begin
          for (int i = 0; i < TN; i++)
            for (int j = 0; j < TN; j++) begin
              u_reg[i][j] <= gu_w[j][i];
              v_reg[i][j] <= bv_w[j][i];
            end
        end
        ST_MUL:  m_reg      <= m_next;
        ST_OUT1: am_reg     <= am_w;
        ST_OUT2: result_reg <= result_next;
        default: ;
      endcase
    end
  end

  assign result_out = result_reg;

endmodule

// File: tb/tb_tile_controller.sv
// tb_tile_controller: directed and random checks of tile_controller against
// a direct 2-D correlation model computed with 64-bit integer arithmetic.
module tb_tile_controller;
  import winograd_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     start;
  word3x3_t kernel_in;
  word6x6_t tile_in;
  word4x4_t result_out;
  logic     done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tile_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kernel_in(kernel_in), .tile_in(tile_in),
    .result_out(result_out), .done(done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Y[i][j] = low 32 bits of sum g[u][v]*d[i+u][j+v]
  function automatic word4x4_t ref_tile(input word3x3_t k, input word6x6_t d);
    word4x4_t r;
    longint   acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int u = 0; u < 3; u++)
          for (int v = 0; v < 3; v++)
            acc += longint'($signed(k[u][v])) * longint'($signed(d[i+u][j+v]));
        r[i][j] = acc[31:0];
      end
    return r;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input word4x4_t obs, input word4x4_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) kernel_in[i][j] = $urandom;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) tile_in[i][j] = $urandom;
  endtask

  // Present inputs with start high across one rising edge (E0), then
  // immediately scramble the inputs; returns at the falling edge after E0.
  task automatic pulse_start(input word3x3_t k, input word6x6_t d);
    @(negedge clk);
    kernel_in = k;
    tile_in   = d;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic run_tile(input string tag, input word3x3_t k, input word6x6_t d);
    word4x4_t exp;
    int       cyc;
    exp = ref_tile(k, d);
    pulse_start(k, d);
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin cyc = c; break; end
    end
    check_int({tag, "_latency"}, cyc, 5);
    check_res({tag, "_result"}, result_out, exp);
    @(posedge clk); #1;
    check_int({tag, "_done_fall"}, int'(done), 0);
    $display("tile %s: latency %0d result %h", tag, cyc, result_out);
  endtask

  word3x3_t k, k2;
  word6x6_t d, d2;
  word4x4_t exp_a;
  int       first_done, second_done, done_count;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    kernel_in = '0;
    tile_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_res("reset_result", result_out, '0);
    check_int("reset_done", int'(done), 0);
    rst_n = 1'b0;

    // identity kernel, d = 6i+j+1
    k = '0; k[1][1] = 32'd1;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = 32'(6*i + j + 1);
    run_tile("identity", k, d);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp_a[i][j] = 32'(6*i + j + 8);
    check_res("identity_closed_form", result_out, exp_a);

    // all ones
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = 32'd1;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = 32'd1;
    run_tile("ones", k, d);

    // kernel 1..9, d = (i+j)%10+1
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = 32'(3*i + j + 1);
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = 32'((i + j) % 10 + 1);
    run_tile("ramp", k, d);
    check_int("ramp_y00", int'($signed(result_out[0][0])), 159);
    check_int("ramp_y03", int'($signed(result_out[0][3])), 294);
    check_int("ramp_y33", int'($signed(result_out[3][3])), 339);

    // signed
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = 32'd1000;
    run_tile("signed", k, d);
    check_int("signed_y12", int'($signed(result_out[1][2])), -9000);

    // overflow wrap
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = 32'h7FFF_FFFF;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = 32'd2;
    run_tile("wrap", k, d);
    check_int("wrap_y21", int'(result_out[2][1]), int'(32'hFFFF_FFEE));

    // reset asserted while in MUL: no done, result cleared
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k[i][j] = $urandom;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d[i][j] = $urandom;
    pulse_start(k, d);
    @(posedge clk);   // E1: now XF2
    @(posedge clk);   // E2: now MUL
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_res("midreset_result", result_out, '0);
    done_count = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) done_count++;
    end
    check_int("midreset_no_done", done_count, 0);
    check_res("midreset_result_held", result_out, '0);
    $display("tile midreset: done pulses %0d result %h", done_count, result_out);
    run_tile("after_reset", k, d);

    // second start while busy is dropped
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin k[i][j] = $urandom; k2[i][j] = $urandom; end
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) begin d[i][j] = $urandom; d2[i][j] = $urandom; end
    exp_a = ref_tile(k, d);
    pulse_start(k, d);
    first_done = -1; done_count = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_count++;
        if (first_done < 0) first_done = c;
      end
      if (c == 2) begin kernel_in = k2; tile_in = d2; start = 1'b1; end
      if (c == 3) start = 1'b0;
    end
    check_int("busy_done_count", done_count, 1);
    check_int("busy_latency", first_done, 5);
    check_res("busy_result", result_out, exp_a);
    $display("tile busy_start: done pulses %0d at %0d result %h", done_count, first_done, result_out);

    // start held high: one tile per 7 cycles
    exp_a = ref_tile(k2, d2);
    @(negedge clk);
    kernel_in = k2; tile_in = d2; start = 1'b1;
    @(posedge clk);   // E0
    first_done = -1; second_done = -1; done_count = 0;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_count++;
        if (first_done < 0) first_done = c; else second_done = c;
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_int("held_done_count", done_count, 2);
    check_int("held_first", first_done, 5);
    check_int("held_second", second_done, 12);
    check_res("held_result", result_out, exp_a);
    $display("tile held_start: done at %0d and %0d result %h", first_done, second_done, result_out);

    // random tiles: full-range and small signed values
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
        k[i][j] = (n < 8) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++)
        d[i][j] = (n < 8) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
      run_tile($sformatf("random%0d", n), k, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
